// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline boundary: 2-entry skid buffer (main + skid) with a decode bypass lookup.
// Define EX_MEM_FWD_EN to build the forwarding lookup; otherwise hit/data outputs are tied to 0.
module ex_mem_skid #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic              hit1_o,
    output logic [DATA_W-1:0] data1_o,
    output logic              hit2_o,
    output logic [DATA_W-1:0] data2_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_main_wd;
    logic                r_main_wreg;
    logic [DATA_W-1:0]   r_main_data;
    logic [ADDR_W-1:0]   r_skid_wd;
    logic                r_skid_wreg;
    logic [DATA_W-1:0]   r_skid_data;

    logic                w_push;
    logic                w_pop;
    logic                w_main_from_in;
    logic                w_main_from_skid;
    logic                w_skid_from_in;

    // Ready depends only on the registered state so MEM stalls never reach EX combinationally.
    assign ex_ready_o  = (r_state != ST_TWO);
    assign mem_valid_o = (r_state != ST_EMPTY);

    assign w_push = ex_valid_i & ex_ready_o;
    assign w_pop  = mem_valid_o & mem_ready_i;

    assign wd_o    = r_main_wd;
    assign wreg_o  = r_main_wreg;
    assign wdata_o = r_main_data;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;
        if (flush_i) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_main_from_in = 1'b1;
                        w_state_nxt    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        w_main_from_in = 1'b1;
                    end else if (w_push) begin
                        w_skid_from_in = 1'b1;
                        w_state_nxt    = ST_TWO;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        w_main_from_skid = 1'b1;
                        w_state_nxt      = ST_ONE;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_main_wd   <= '0;
            r_main_wreg <= 1'b0;
            r_main_data <= '0;
        end else if (w_main_from_in) begin
            r_main_wd   <= wd_i;
            r_main_wreg <= wreg_i;
            r_main_data <= wdata_i;
        end else if (w_main_from_skid) begin
            r_main_wd   <= r_skid_wd;
            r_main_wreg <= r_skid_wreg;
            r_main_data <= r_skid_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_skid_wd   <= '0;
            r_skid_wreg <= 1'b0;
            r_skid_data <= '0;
        end else if (w_skid_from_in) begin
            r_skid_wd   <= wd_i;
            r_skid_wreg <= wreg_i;
            r_skid_data <= wdata_i;
        end
    end

`ifdef EX_MEM_FWD_EN
    logic w_main_vld;
    logic w_skid_vld;
    logic w_hit1_main;
    logic w_hit1_skid;
    logic w_hit2_main;
    logic w_hit2_skid;

    function automatic logic entry_match(input logic [ADDR_W-1:0] ra,
                                         input logic              vld,
                                         input logic              wreg,
                                         input logic [ADDR_W-1:0] wd);
        return (ra != '0) && vld && wreg && (wd == ra);
    endfunction

    assign w_main_vld = (r_state != ST_EMPTY);
    assign w_skid_vld = (r_state == ST_TWO);

    assign w_hit1_main = entry_match(raddr1_i, w_main_vld, r_main_wreg, r_main_wd);
    assign w_hit1_skid = entry_match(raddr1_i, w_skid_vld, r_skid_wreg, r_skid_wd);
    assign w_hit2_main = entry_match(raddr2_i, w_main_vld, r_main_wreg, r_main_wd);
    assign w_hit2_skid = entry_match(raddr2_i, w_skid_vld, r_skid_wreg, r_skid_wd);

    // The skid entry is younger, so it wins when both entries target the same register.
    assign hit1_o  = w_hit1_main | w_hit1_skid;
    assign data1_o = w_hit1_skid ? r_skid_data : (w_hit1_main ? r_main_data : '0);
    assign hit2_o  = w_hit2_main | w_hit2_skid;
    assign data2_o = w_hit2_skid ? r_skid_data : (w_hit2_main ? r_main_data : '0);
`else
    logic w_unused_raddr;

    assign w_unused_raddr = ^{raddr1_i, raddr2_i};
    assign hit1_o  = 1'b0;
    assign data1_o = '0;
    assign hit2_o  = 1'b0;
    assign data2_o = '0;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Self-checking bench for ex_mem_skid: scoreboard of pushed entries compared on every pop.
module tb_ex_mem_skid;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int ENT_W  = ADDR_W + 1 + DATA_W;
`ifdef EX_MEM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic              ex_valid_i;
    logic              ex_ready_o;
    logic [ADDR_W-1:0] wd_i;
    logic              wreg_i;
    logic [DATA_W-1:0] wdata_i;
    logic              mem_valid_o;
    logic              mem_ready_i;
    logic [ADDR_W-1:0] wd_o;
    logic              wreg_o;
    logic [DATA_W-1:0] wdata_o;
    logic [ADDR_W-1:0] raddr1_i;
    logic [ADDR_W-1:0] raddr2_i;
    logic              hit1_o;
    logic [DATA_W-1:0] data1_o;
    logic              hit2_o;
    logic [DATA_W-1:0] data2_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [ENT_W-1:0] sb[$];

    ex_mem_skid #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .ex_valid_i  (ex_valid_i),
        .ex_ready_o  (ex_ready_o),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .mem_valid_o (mem_valid_o),
        .mem_ready_i (mem_ready_i),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .raddr1_i    (raddr1_i),
        .raddr2_i    (raddr2_i),
        .hit1_o      (hit1_o),
        .data1_o     (data1_o),
        .hit2_o      (hit2_o),
        .data2_o     (data2_o)
    );

    always #5 clk_i = ~clk_i;

    // One clock: account for the push/pop about to happen, advance, then check occupancy flags.
    task automatic tick();
        logic push;
        logic pop;
        logic [ENT_W-1:0] exp;
        #1;
        push = ex_valid_i & ex_ready_o;
        pop  = mem_valid_o & mem_ready_i;
        if (rst_i || flush_i) begin
            sb.delete();
        end else begin
            if (pop) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_on_empty: got valid entry wd=%0d data=%h, required none", wd_o, wdata_o);
                end else begin
                    exp = sb.pop_front();
                    if ({wd_o, wreg_o, wdata_o} !== exp) begin
                        n_fail++;
                        $display("FAIL pop_order: got wd=%0d wreg=%0b data=%h, required wd=%0d wreg=%0b data=%h",
                                 wd_o, wreg_o, wdata_o, exp[ENT_W-1 -: ADDR_W], exp[DATA_W],
                                 exp[DATA_W-1:0]);
                    end
                end
            end
            if (push) sb.push_back({wd_i, wreg_i, wdata_i});
        end
        @(posedge clk_i);
        @(negedge clk_i);
        n_checks++;
        if (mem_valid_o !== (sb.size() != 0)) begin
            n_fail++;
            $display("FAIL mem_valid: got %0b, required %0b", mem_valid_o, sb.size() != 0);
        end
        n_checks++;
        if (ex_ready_o !== (sb.size() < 2)) begin
            n_fail++;
            $display("FAIL ex_ready: got %0b, required %0b", ex_ready_o, sb.size() < 2);
        end
    endtask

    task automatic drive_push(input logic [ADDR_W-1:0] wd, input logic wreg, input logic [DATA_W-1:0] d);
        ex_valid_i = 1'b1;
        wd_i       = wd;
        wreg_i     = wreg;
        wdata_i    = d;
    endtask

    task automatic idle_in();
        ex_valid_i = 1'b0;
        wd_i       = '0;
        wreg_i     = 1'b0;
        wdata_i    = '0;
    endtask

    task automatic drain();
        idle_in();
        mem_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        raddr1_i = 5'd3;
        raddr2_i = 5'd0;
        #1;
        n_checks++;
        if ({mem_valid_o, ex_ready_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_flags: got valid=%0b ready=%0b, required 0/1", mem_valid_o, ex_ready_o);
        end
        n_checks++;
        if ({wd_o, wreg_o, wdata_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got wd=%0d wreg=%0b data=%h, required zeros", wd_o, wreg_o, wdata_o);
        end
        n_checks++;
        if ({hit1_o, hit2_o, data1_o, data2_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_fwd: got hit1=%0b hit2=%0b d1=%h d2=%h, required zeros",
                     hit1_o, hit2_o, data1_o, data2_o);
        end
        tick();
    endtask

    task automatic test_stream();
        mem_ready_i = 1'b1;
        drive_push(5'd3, 1'b1, 32'h11);
        tick();
        n_checks++;
        if ({wd_o, wdata_o} !== {5'd3, 32'h11}) begin
            n_fail++;
            $display("FAIL stream_first: got wd=%0d data=%h, required wd=3 data=11", wd_o, wdata_o);
        end
        drive_push(5'd4, 1'b1, 32'h22);
        tick();
        n_checks++;
        if ({wd_o, wdata_o, ex_ready_o} !== {5'd4, 32'h22, 1'b1}) begin
            n_fail++;
            $display("FAIL stream_second: got wd=%0d data=%h ready=%0b, required wd=4 data=22 ready=1",
                     wd_o, wdata_o, ex_ready_o);
        end
        idle_in();
        tick();
        tick();
    endtask

    task automatic test_skid();
        mem_ready_i = 1'b0;
        drive_push(5'd1, 1'b1, 32'hA);
        tick();
        drive_push(5'd2, 1'b1, 32'hB);
        tick();
        n_checks++;
        if ({ex_ready_o, wdata_o} !== {1'b0, 32'hA}) begin
            n_fail++;
            $display("FAIL skid_full: got ready=%0b data=%h, required ready=0 data=a", ex_ready_o, wdata_o);
        end
        idle_in();
        mem_ready_i = 1'b1;
        tick();
        n_checks++;
        if ({mem_valid_o, wdata_o} !== {1'b1, 32'hB}) begin
            n_fail++;
            $display("FAIL skid_second: got valid=%0b data=%h, required valid=1 data=b", mem_valid_o, wdata_o);
        end
        tick();
        n_checks++;
        if (mem_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL skid_empty: got valid=%0b, required 0", mem_valid_o);
        end
    endtask

    task automatic test_forward();
        mem_ready_i = 1'b0;
        raddr1_i = 5'd6;
        raddr2_i = 5'd0;
        drive_push(5'd6, 1'b1, 32'h61);
        #1;
        n_checks++;
        if (hit1_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_no_bypass: got hit1=%0b, required 0", hit1_o);
        end
        drain();
        mem_ready_i = 1'b0;
        drive_push(5'd5, 1'b1, 32'h55);
        tick();
        raddr1_i = 5'd5;
        #1;
        n_checks++;
        if ({hit1_o, data1_o} !== {FWD, FWD ? 32'h55 : 32'h0}) begin
            n_fail++;
            $display("FAIL fwd_main: got hit1=%0b d1=%h, required %0b/%h", hit1_o, data1_o, FWD,
                     FWD ? 32'h55 : 32'h0);
        end
        drive_push(5'd5, 1'b1, 32'h66);
        tick();
        idle_in();
        #1;
        n_checks++;
        if ({hit1_o, data1_o} !== {FWD, FWD ? 32'h66 : 32'h0}) begin
            n_fail++;
            $display("FAIL fwd_skid_wins: got hit1=%0b d1=%h, required %0b/%h", hit1_o, data1_o, FWD,
                     FWD ? 32'h66 : 32'h0);
        end
        n_checks++;
        if ({hit2_o, data2_o} !== '0) begin
            n_fail++;
            $display("FAIL fwd_raddr0: got hit2=%0b d2=%h, required 0/0", hit2_o, data2_o);
        end
        n_checks++;
        if ({wdata_o, ex_ready_o} !== {32'h55, 1'b0}) begin
            n_fail++;
            $display("FAIL fwd_handshake: got data=%h ready=%0b, required 55/0", wdata_o, ex_ready_o);
        end
        drain();
        mem_ready_i = 1'b0;
        drive_push(5'd7, 1'b0, 32'h77);
        tick();
        idle_in();
        raddr2_i = 5'd7;
        #1;
        n_checks++;
        if ({hit2_o, data2_o} !== '0) begin
            n_fail++;
            $display("FAIL fwd_wreg0: got hit2=%0b d2=%h, required 0/0", hit2_o, data2_o);
        end
        drain();
    endtask

    task automatic test_flush();
        mem_ready_i = 1'b0;
        raddr1_i = 5'd8;
        raddr2_i = 5'd9;
        drive_push(5'd8, 1'b1, 32'h80);
        tick();
        drive_push(5'd9, 1'b1, 32'h90);
        tick();
        idle_in();
        flush_i = 1'b1;
        mem_ready_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1;
        n_checks++;
        if ({mem_valid_o, ex_ready_o, hit1_o, hit2_o} !== 4'b0100) begin
            n_fail++;
            $display("FAIL flush_two: got valid=%0b ready=%0b hit1=%0b hit2=%0b, required 0/1/0/0",
                     mem_valid_o, ex_ready_o, hit1_o, hit2_o);
        end
        drive_push(5'd8, 1'b1, 32'h81);
        tick();
        drive_push(5'd9, 1'b1, 32'h91);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        idle_in();
        #1;
        n_checks++;
        if ({mem_valid_o, hit2_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_push: got valid=%0b hit2=%0b, required 0/0", mem_valid_o, hit2_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        mem_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_push(5'(i + 10), 1'b1, 32'hC0 + 32'(i));
            tick();
            n_checks++;
            if (wdata_o !== 32'hC0 + 32'(i)) begin
                n_fail++;
                $display("FAIL b2b_data: got %h, required %h", wdata_o, 32'hC0 + 32'(i));
            end
        end
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) != 0) drive_push(5'($urandom), 1'($urandom), $urandom);
            else idle_in();
            mem_ready_i = 1'($urandom_range(0, 3) != 0);
            raddr1_i = 5'($urandom);
            raddr2_i = 5'($urandom);
            tick();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        mem_ready_i = 1'b0;
        drive_push(5'd12, 1'b1, 32'hDEAD);
        tick();
        drive_push(5'd13, 1'b1, 32'hBEEF);
        tick();
        idle_in();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n_checks++;
        if ({mem_valid_o, ex_ready_o, wd_o, wreg_o, wdata_o} !== {2'b01, {(ENT_W){1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_mid: got valid=%0b ready=%0b wd=%0d wreg=%0b data=%h, required 0/1/zeros",
                     mem_valid_o, ex_ready_o, wd_o, wreg_o, wdata_o);
        end
        tick();
    endtask

    initial begin
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        mem_ready_i = 1'b0;
        raddr1_i    = '0;
        raddr2_i    = '0;
        idle_in();
        @(negedge clk_i);
        test_reset();
        test_stream();
        test_skid();
        test_forward();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
